usb_sie_tx_ctrl: RTL and testbench
==================================

Name: usb_sie_tx_ctrl

Overview:
Transmit-side packet controller sitting between the SIE/endpoint logic and the UTM transmit interface (UTMI data_in/tx_valid/tx_ready).
- Arbitrates between a handshake requester and a data-packet requester.
- Builds the PID byte, streams payload from an endpoint buffer, and appends the CRC16.
- Enforces bus turnaround (no start while rx_active) and a minimum inter-packet gap.

Parameters:
MAX_PKT_SIZE, 64, maximum payload bytes; longer data_len is clamped to this value.
GAP_CYCLES, 16, clk cycles after a packet's last accepted byte before the next grant is allowed.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
hs_req  in  1  handshake packet request (level)
hs_pid  in  4  handshake PID (ACK=4'h2, NAK=4'hA, STALL=4'hE)
hs_gnt  out  1  one-cycle pulse: handshake request granted, hs_pid captured
data_req  in  1  data packet request (level)
data_pid  in  4  data PID (DATA0=4'h3, DATA1=4'hB)
data_len  in  11  payload byte count, sampled at grant
data_gnt  out  1  one-cycle pulse: data request granted
pl_data  in  8  payload byte, first-word-fall-through
pl_rd  out  1  pop strobe; pl_data must present the next byte on the following cycle
tx_done  out  1  one-cycle pulse after the last byte of any packet is accepted
busy  out  1  high from grant until gap expiry
rx_active  in  1  receive in progress; blocks a new grant
utmi_data_out  out  8  byte to UTM data_in
utmi_tx_valid  out  1  to UTM tx_valid
utmi_tx_ready  in  1  from UTM tx_ready; one-cycle byte-accept pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; gap counter cleared, so no gap is enforced after reset.
- Byte accept: a byte is accepted in a cycle with utmi_tx_valid && utmi_tx_ready. The next byte is registered onto utmi_data_out in the following cycle.
- Stability: utmi_data_out is held stable while waiting for acceptance.
- Grant conditions: grant occurs in IDLE when (hs_req || data_req) && !rx_active.
  - Fixed priority: handshake over data. On simultaneous requests the handshake wins and data stays pending.
  - At grant: capture PID, clamped length, and packet type; pulse hs_gnt or data_gnt.
  - Requests are ignored from grant until the FSM returns to IDLE.
  - A request withdrawn before grant has no effect.
- PID byte: {~pid, pid}. Examples: ACK -> 8'hD2, DATA1 -> 8'h4B.
- FSM states:
  - IDLE -> SEND_PID on grant. utmi_tx_valid rises the cycle after grant, carrying the PID byte.
  - SEND_PID, on accept:
    - handshake -> GAP;
    - data with len 0 -> CRC_LO;
    - otherwise -> SEND_DATA, with utmi_data_out = pl_data.
  - SEND_DATA, on accept: pl_rd pulses that same cycle; the CRC is updated with the accepted byte; the byte counter increments. When the counter reaches len -> CRC_LO.
  - CRC_LO: sends ~crc[7:0]; on accept -> CRC_HI.
  - CRC_HI: sends ~crc[15:8]; on accept -> GAP.
- GAP:
  - utmi_tx_valid deasserts the cycle after the last accept, with tx_done pulsing that same cycle.
  - The gap counter loads GAP_CYCLES-1 and counts down to 0, then -> IDLE.
  - busy drops on entry to IDLE.
- CRC16: polynomial 0x8005, LSB-first (reflected 0xA001), init 16'hFFFF at grant; transmitted inverted, low byte first. A ZLP yields CRC bytes 8'h00, 8'h00.
- Widths: byte counter is 11 bits and never wraps, since len <= MAX_PKT_SIZE.
- rx_active during transmission: ignored; it only gates grant.
- No abort path: once granted, a packet always completes.
- Reset mid-packet: utmi_tx_valid drops asynchronously and the FSM returns to IDLE. No done pulse is issued. The UTM is responsible for line cleanup.

Decomposition:
- usb_pkt_pkg holds:
  - usb_pid_t enum;
  - constants: PID values, CRC16 polynomial/init/residual;
  - function usb_crc16_byte(crc, byte) for the reflected byte-wide update.
- Sub-module usb_crc16: registered 16-bit CRC with init and en ports and byte input, reusable by the receive side.
- The arbiter stays inline.

Test Plan:
- ACK: hs_req, hs_pid=4'h2, ready pulses every 8 cycles -> hs_gnt one cycle; one byte 8'hD2; tx_done; busy held GAP_CYCLES after.
- DATA0 ZLP: data_len=0, data_pid=4'h3 -> bytes C3, 00, 00; pl_rd never asserts.
- DATA1, payload 01 02 03 04 -> bytes 4B, 01, 02, 03, 04, then two CRC bytes matching the reference model; exactly 4 pl_rd pulses.
- Simultaneous hs_req and data_req -> handshake sent first; data granted only after GAP expires; rx_active high holds the grant off until it falls.
- data_len=100 with MAX_PKT_SIZE=64 -> exactly 64 payload bytes plus CRC.
- Async rst asserted mid-SEND_DATA -> utmi_tx_valid 0 immediately, all outputs 0, no tx_done; a new hs_req after release is granted with no gap.

Source files
------------

// File: rtl/usb_pkt_pkg.sv
// Shared USB packet definitions for the SIE transmit and receive paths.
//   usb_pid_t       : 4-bit PID encodings used by this SIE
//   tx_state_t      : transmit controller FSM states
//   CRC16_*         : CRC16 constants (polynomial 0x8005, reflected form 0xA001)
//   usb_crc16_byte  : one byte of reflected (LSB-first) CRC16 update
//   usb_pid_byte    : PID byte as sent on the wire, {~pid, pid}
package usb_pkt_pkg;

  typedef enum logic [3:0] {
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB
  } usb_pid_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND_PID,
    TX_SEND_DATA,
    TX_CRC_LO,
    TX_CRC_HI,
    TX_GAP
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  // Remainder left in the reflected register after a good packet (data + CRC).
  localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

  // Bits enter LSB first, matching USB bit order on the wire.
  function automatic logic [15:0] usb_crc16_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] usb_pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Registered byte-wide USB CRC16 (reflected 0xA001, init 16'hFFFF).
//   clk  : clock
//   rst  : asynchronous active-high reset, loads the init value
//   init : synchronous reload of the init value (start of packet)
//   en   : fold data into the CRC this cycle
//   data : byte to fold in
//   crc  : current CRC register (not inverted)
module usb_crc16
  import usb_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc_q <= CRC16_INIT;
    else if (init) crc_q <= CRC16_INIT;
    else if (en)   crc_q <= usb_crc16_byte(crc_q, data);
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_sie_tx_ctrl.sv
// USB SIE transmit packet controller feeding the UTMI transmit interface.
// Arbitrates handshake (priority) and data packet requests, sends the PID
// byte, streams payload from a first-word-fall-through endpoint buffer,
// appends the inverted CRC16 low byte first, then holds off the next grant
// for GAP_CYCLES cycles.
//   clk, rst           : clock, asynchronous active-high reset
//   hs_req/hs_pid      : handshake request (level) and PID
//   hs_gnt             : one-cycle grant pulse for the handshake
//   data_req/data_pid  : data packet request (level) and PID
//   data_len           : payload length, sampled at grant, clamped to MAX_PKT_SIZE
//   data_gnt           : one-cycle grant pulse for the data packet
//   pl_data/pl_rd      : payload byte (FWFT) and its pop strobe
//   tx_done            : pulse the cycle after the last byte is accepted
//   busy               : high while a packet or its gap is in progress
//   rx_active          : receive in progress, blocks new grants
//   utmi_data_out/utmi_tx_valid/utmi_tx_ready : UTMI transmit handshake
module usb_sie_tx_ctrl
  import usb_pkt_pkg::*;
#(
  parameter int MAX_PKT_SIZE = 64,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_req,
  input  logic [3:0]  hs_pid,
  output logic        hs_gnt,
  input  logic        data_req,
  input  logic [3:0]  data_pid,
  input  logic [10:0] data_len,
  output logic        data_gnt,
  input  logic [7:0]  pl_data,
  output logic        pl_rd,
  output logic        tx_done,
  output logic        busy,
  input  logic        rx_active,
  output logic [7:0]  utmi_data_out,
  output logic        utmi_tx_valid,
  input  logic        utmi_tx_ready
);

  localparam int          GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PKT_SIZE);

  tx_state_t        state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic             done_q;

  // Packet context, captured at grant; only meaningful outside IDLE.
  logic             is_hs_q;
  logic [3:0]       pid_q;
  logic [10:0]      len_q;
  logic [10:0]      cnt_q;

  logic        idle;
  logic        grant_hs, grant_data, grant;
  logic        accept;
  logic        last_payload;
  logic        last_accept;
  logic        crc_en;
  logic [10:0] clamped_len;
  logic [15:0] crc;

  assign idle        = (state_q == TX_IDLE);
  // Handshake wins; data stays pending while hs_req is up.
  assign grant_hs    = idle && hs_req && !rx_active;
  assign grant_data  = idle && !hs_req && data_req && !rx_active;
  assign grant       = grant_hs || grant_data;
  assign clamped_len = (data_len > MAX_LEN) ? MAX_LEN : data_len;
  assign accept      = utmi_tx_valid && utmi_tx_ready;
  assign last_payload = ((cnt_q + 11'd1) == len_q);
  assign crc_en      = (state_q == TX_SEND_DATA) && accept;

  usb_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (grant),
    .en   (crc_en),
    .data (pl_data),
    .crc  (crc)
  );

  // Next state and outputs
  always_comb begin
    state_d       = state_q;
    utmi_tx_valid = 1'b0;
    utmi_data_out = 8'h00;
    pl_rd         = 1'b0;
    last_accept   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (grant) state_d = TX_SEND_PID;
      end
      TX_SEND_PID: begin
        utmi_tx_valid = 1'b1;
        utmi_data_out = usb_pid_byte(pid_q);
        if (utmi_tx_ready) begin
          if (is_hs_q) begin
            state_d     = TX_GAP;
            last_accept = 1'b1;
          end else if (len_q == 11'd0) begin
            state_d = TX_CRC_LO;
          end else begin
            state_d = TX_SEND_DATA;
          end
        end
      end
      TX_SEND_DATA: begin
        // The FWFT head is the output register here: it stays stable until
        // popped and shows the next byte the cycle after the pop.
        utmi_tx_valid = 1'b1;
        utmi_data_out = pl_data;
        pl_rd         = utmi_tx_ready;
        if (utmi_tx_ready && last_payload) state_d = TX_CRC_LO;
      end
      TX_CRC_LO: begin
        utmi_tx_valid = 1'b1;
        utmi_data_out = ~crc[7:0];
        if (utmi_tx_ready) state_d = TX_CRC_HI;
      end
      TX_CRC_HI: begin
        utmi_tx_valid = 1'b1;
        utmi_data_out = ~crc[15:8];
        if (utmi_tx_ready) begin
          state_d     = TX_GAP;
          last_accept = 1'b1;
        end
      end
      TX_GAP: begin
        if (gap_q == '0) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign hs_gnt   = grant_hs;
  assign data_gnt = grant_data;
  assign busy     = !idle;
  assign tx_done  = done_q;

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_accept;
      if (last_accept)                          gap_q <= GAP_LOAD;
      else if (state_q == TX_GAP && gap_q != '0) gap_q <= gap_q - 1'b1;
    end
  end

  // Packet context registers
  always_ff @(posedge clk) begin
    if (grant) begin
      is_hs_q <= grant_hs;
      pid_q   <= grant_hs ? hs_pid : data_pid;
      len_q   <= grant_hs ? 11'd0 : clamped_len;
      cnt_q   <= 11'd0;
    end else if (crc_en) begin
      cnt_q <= cnt_q + 11'd1;
    end
  end

endmodule

// File: tb/tb_usb_sie_tx_ctrl.sv
// Directed bench for usb_sie_tx_ctrl: handshake, ZLP, short data packet,
// arbitration with gap and rx_active hold-off, length clamp, async reset.
module tb_usb_sie_tx_ctrl;
  import usb_pkt_pkg::*;

  localparam int MAXP = 64;
  localparam int GAP  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_req = 1'b0;
  logic [3:0]  hs_pid = 4'h0;
  logic        hs_gnt;
  logic        data_req = 1'b0;
  logic [3:0]  data_pid = 4'h0;
  logic [10:0] data_len = 11'd0;
  logic        data_gnt;
  logic [7:0]  pl_data = 8'h00;
  logic        pl_rd;
  logic        tx_done;
  logic        busy;
  logic        rx_active = 1'b0;
  logic [7:0]  utmi_data_out;
  logic        utmi_tx_valid;
  logic        utmi_tx_ready = 1'b0;

  always #5 clk = ~clk;

  usb_sie_tx_ctrl #(.MAX_PKT_SIZE(MAXP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
    .data_req(data_req), .data_pid(data_pid), .data_len(data_len), .data_gnt(data_gnt),
    .pl_data(pl_data), .pl_rd(pl_rd),
    .tx_done(tx_done), .busy(busy), .rx_active(rx_active),
    .utmi_data_out(utmi_data_out), .utmi_tx_valid(utmi_tx_valid), .utmi_tx_ready(utmi_tx_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:255];
  int         pl_idx;
  logic [7:0] rx [0:127];
  int         rx_n, rd_cnt, done_cnt, stray_gnt;
  bit         done_valid_bad, timed_out;

  // Reference CRC in the non-reflected (MSB-first) register domain, fed the
  // data bits LSB first, then bit-reversed into the transmitted orientation.
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  b;
    bit          fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      b = mem[k];
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  // UTM + endpoint buffer model: ready every 'period' cycles, FWFT pops.
  task automatic collect(input int period, input int stop_bytes, input int limit);
    int ctr = 0;
    bit rd_seen = 1'b0;
    bit fin = 1'b0;
    rx_n = 0; rd_cnt = 0; done_cnt = 0; stray_gnt = 0;
    done_valid_bad = 1'b0; timed_out = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      if (rd_seen) begin pl_idx++; pl_data = mem[pl_idx]; end
      utmi_tx_ready = ((ctr % period) == (period - 1));
      ctr++;
      @(negedge clk);
      if (utmi_tx_valid && utmi_tx_ready && rx_n < 128) begin rx[rx_n] = utmi_data_out; rx_n++; end
      rd_seen = pl_rd;
      if (pl_rd) rd_cnt++;
      if (hs_gnt || data_gnt) stray_gnt++;
      if (tx_done) begin
        done_cnt++;
        if (utmi_tx_valid) done_valid_bad = 1'b1;
        fin = 1'b1;
      end
      if (stop_bytes > 0 && rx_n >= stop_bytes) fin = 1'b1;
      if (ctr >= limit) begin timed_out = 1'b1; fin = 1'b1; end
    end
    if (stop_bytes == 0) utmi_tx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (hs_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_hs_gnt: got %0h want 0", hs_gnt); end
    n_cmp++; if (data_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_data_gnt: got %0h want 0", data_gnt); end
    n_cmp++; if (pl_rd !== 1'b0) begin n_bad++; $display("FAIL rst_pl_rd: got %0h want 0", pl_rd); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL rst_tx_done: got %0h want 0", tx_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    n_cmp++; if (utmi_tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %0h want 0", utmi_tx_valid); end
    n_cmp++; if (utmi_data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %0h want 00", utmi_data_out); end
    rst = 1'b0;
  endtask

  task automatic test_ack();
    int extra = 0;
    @(posedge clk); #1;
    hs_pid = PID_ACK; hs_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (hs_gnt !== 1'b1) begin n_bad++; $display("FAIL ack_gnt: got %0h want 1", hs_gnt); end
    n_cmp++; if (data_gnt !== 1'b0) begin n_bad++; $display("FAIL ack_data_gnt: got %0h want 0", data_gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (hs_gnt !== 1'b0) begin n_bad++; $display("FAIL ack_gnt_pulse: got %0h want 0", hs_gnt); end
    n_cmp++; if (utmi_tx_valid !== 1'b1) begin n_bad++; $display("FAIL ack_valid_rise: got %0h want 1", utmi_tx_valid); end
    n_cmp++; if (utmi_data_out !== 8'hD2) begin n_bad++; $display("FAIL ack_pid_byte: got %0h want d2", utmi_data_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ack_busy: got %0h want 1", busy); end
    hs_req = 1'b0;
    collect(8, 0, 200);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ack_timeout: got no tx_done, want tx_done"); end
    n_cmp++; if (rx_n !== 1) begin n_bad++; $display("FAIL ack_nbytes: got %0d want 1", rx_n); end
    n_cmp++; if (rx[0] !== 8'hD2) begin n_bad++; $display("FAIL ack_byte0: got %0h want d2", rx[0]); end
    n_cmp++; if (rd_cnt !== 0) begin n_bad++; $display("FAIL ack_pl_rd: got %0d want 0", rd_cnt); end
    n_cmp++; if (done_valid_bad) begin n_bad++; $display("FAIL ack_valid_at_done: got 1 want 0"); end
    n_cmp++; if (stray_gnt !== 0) begin n_bad++; $display("FAIL ack_stray_gnt: got %0d want 0", stray_gnt); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) extra++; else break;
    end
    n_cmp++; if (1 + extra !== GAP) begin n_bad++; $display("FAIL ack_gap_busy: got %0d want %0d", 1 + extra, GAP); end
  endtask

  task automatic test_zlp();
    @(posedge clk); #1;
    data_pid = PID_DATA0; data_len = 11'd0; data_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_gnt !== 1'b1) begin n_bad++; $display("FAIL zlp_gnt: got %0h want 1", data_gnt); end
    n_cmp++; if (hs_gnt !== 1'b0) begin n_bad++; $display("FAIL zlp_hs_gnt: got %0h want 0", hs_gnt); end
    @(posedge clk); #1;
    data_req = 1'b0;
    collect(1, 0, 100);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL zlp_timeout: got no tx_done, want tx_done"); end
    n_cmp++; if (rx_n !== 3) begin n_bad++; $display("FAIL zlp_nbytes: got %0d want 3", rx_n); end
    n_cmp++; if (rx[0] !== 8'hC3) begin n_bad++; $display("FAIL zlp_pid: got %0h want c3", rx[0]); end
    n_cmp++; if (rx[1] !== 8'h00) begin n_bad++; $display("FAIL zlp_crc_lo: got %0h want 00", rx[1]); end
    n_cmp++; if (rx[2] !== 8'h00) begin n_bad++; $display("FAIL zlp_crc_hi: got %0h want 00", rx[2]); end
    n_cmp++; if (rd_cnt !== 0) begin n_bad++; $display("FAIL zlp_pl_rd: got %0d want 0", rd_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zlp_done: got %0d want 1", done_cnt); end
    wait_idle();
  endtask

  task automatic test_data1();
    logic [15:0] c;
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    c = ref_crc(4);
    pl_idx = 0; pl_data = mem[0];
    @(posedge clk); #1;
    data_pid = PID_DATA1; data_len = 11'd4; data_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_gnt !== 1'b1) begin n_bad++; $display("FAIL d1_gnt: got %0h want 1", data_gnt); end
    @(posedge clk); #1;
    data_req = 1'b0;
    collect(3, 0, 200);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL d1_timeout: got no tx_done, want tx_done"); end
    n_cmp++; if (rx_n !== 7) begin n_bad++; $display("FAIL d1_nbytes: got %0d want 7", rx_n); end
    n_cmp++; if (rx[0] !== 8'h4B) begin n_bad++; $display("FAIL d1_pid: got %0h want 4b", rx[0]); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rx[i] !== 8'(i)) begin n_bad++; $display("FAIL d1_payload[%0d]: got %0h want %0h", i, rx[i], i); end
    end
    n_cmp++; if (rx[5] !== ~c[7:0]) begin n_bad++; $display("FAIL d1_crc_lo: got %0h want %0h", rx[5], ~c[7:0]); end
    n_cmp++; if (rx[6] !== ~c[15:8]) begin n_bad++; $display("FAIL d1_crc_hi: got %0h want %0h", rx[6], ~c[15:8]); end
    n_cmp++; if (rd_cnt !== 4) begin n_bad++; $display("FAIL d1_pl_rd: got %0d want 4", rd_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL d1_done: got %0d want 1", done_cnt); end
    wait_idle();
  endtask

  task automatic test_priority();
    int early = 0;
    int short_gap = 0;
    @(posedge clk); #1;
    hs_pid = PID_NAK; hs_req = 1'b1;
    data_pid = PID_DATA0; data_len = 11'd0; data_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (hs_gnt !== 1'b1) begin n_bad++; $display("FAIL pri_hs_gnt: got %0h want 1", hs_gnt); end
    n_cmp++; if (data_gnt !== 1'b0) begin n_bad++; $display("FAIL pri_data_gnt: got %0h want 0", data_gnt); end
    @(posedge clk); #1;
    hs_req = 1'b0;
    collect(2, 0, 100);
    n_cmp++; if (rx_n !== 1 || rx[0] !== 8'h5A) begin n_bad++; $display("FAIL pri_nak: got %0d bytes first %0h want 1 byte 5a", rx_n, rx[0]); end
    n_cmp++; if (stray_gnt !== 0) begin n_bad++; $display("FAIL pri_stray_gnt: got %0d want 0", stray_gnt); end
    // Now in the first gap cycle; data_req still held.
    for (int i = 0; i < GAP - 2; i++) begin
      @(negedge clk);
      if (data_gnt) early++;
      if (!busy) short_gap++;
    end
    rx_active = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pri_gap_last: got busy %0h want 1", busy); end
    if (data_gnt) early++;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pri_gap_end: got busy %0h want 0", busy); end
    if (data_gnt) early++;
    repeat (3) begin
      @(negedge clk);
      if (data_gnt) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL pri_early_gnt: got %0d want 0", early); end
    n_cmp++; if (short_gap !== 0) begin n_bad++; $display("FAIL pri_short_gap: got %0d want 0", short_gap); end
    @(posedge clk); #1;
    rx_active = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_gnt !== 1'b1) begin n_bad++; $display("FAIL pri_data_after: got %0h want 1", data_gnt); end
    @(posedge clk); #1;
    data_req = 1'b0;
    collect(1, 0, 100);
    n_cmp++; if (rx_n !== 3 || rx[0] !== 8'hC3) begin n_bad++; $display("FAIL pri_data_pkt: got %0d bytes first %0h want 3 bytes c3", rx_n, rx[0]); end
    wait_idle();
  endtask

  task automatic test_clamp();
    logic [15:0] c;
    int bad_bytes = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    c = ref_crc(MAXP);
    pl_idx = 0; pl_data = mem[0];
    @(posedge clk); #1;
    data_pid = PID_DATA1; data_len = 11'd100; data_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_gnt !== 1'b1) begin n_bad++; $display("FAIL clamp_gnt: got %0h want 1", data_gnt); end
    @(posedge clk); #1;
    data_req = 1'b0;
    collect(1, 0, 300);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL clamp_timeout: got no tx_done, want tx_done"); end
    n_cmp++; if (rx_n !== MAXP + 3) begin n_bad++; $display("FAIL clamp_nbytes: got %0d want %0d", rx_n, MAXP + 3); end
    n_cmp++; if (rd_cnt !== MAXP) begin n_bad++; $display("FAIL clamp_pl_rd: got %0d want %0d", rd_cnt, MAXP); end
    for (int i = 1; i <= MAXP; i++) if (rx[i] !== 8'(i)) bad_bytes++;
    n_cmp++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL clamp_payload: got %0d wrong bytes want 0", bad_bytes); end
    n_cmp++; if (rx[MAXP+1] !== ~c[7:0] || rx[MAXP+2] !== ~c[15:8]) begin
      n_bad++; $display("FAIL clamp_crc: got %0h %0h want %0h %0h", rx[MAXP+1], rx[MAXP+2], ~c[7:0], ~c[15:8]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    pl_idx = 0; pl_data = mem[0];
    @(posedge clk); #1;
    data_pid = PID_DATA0; data_len = 11'd10; data_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_gnt !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt: got %0h want 1", data_gnt); end
    @(posedge clk); #1;
    data_req = 1'b0;
    collect(1, 4, 100);
    n_cmp++; if (utmi_tx_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_mid_valid: got %0h want 1", utmi_tx_valid); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (utmi_tx_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_async: got %0h want 0", utmi_tx_valid); end
    n_cmp++; if (utmi_data_out !== 8'h00) begin n_bad++; $display("FAIL rmid_data_out: got %0h want 00", utmi_data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %0h want 0", busy); end
    n_cmp++; if (pl_rd !== 1'b0) begin n_bad++; $display("FAIL rmid_pl_rd: got %0h want 0", pl_rd); end
    utmi_tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done) dones++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (tx_done) dones++;
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
    @(posedge clk); #1;
    hs_pid = PID_STALL; hs_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (hs_gnt !== 1'b1) begin n_bad++; $display("FAIL rmid_regrant: got %0h want 1", hs_gnt); end
    @(posedge clk); #1;
    hs_req = 1'b0;
    collect(1, 0, 50);
    n_cmp++; if (rx_n !== 1 || rx[0] !== 8'h1E) begin n_bad++; $display("FAIL rmid_stall: got %0d bytes first %0h want 1 byte 1e", rx_n, rx[0]); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rmid_stall_done: got %0d want 1", done_cnt); end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    pl_idx = 0;
    test_reset();
    test_ack();
    test_zlp();
    test_data1();
    test_priority();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
